// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the pins, checks 11-bit frames, decodes E0/F0
// prefixes into key events queued in a first-word-fall-through FIFO with valid/ready.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4,
  parameter int STROBE_CYCLES  = 10000000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_release,
  output logic       evt_extended,
  output logic [4:0] scancode1,
  output logic [4:0] scancode0,
  output logic       strobe_out,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W  = $clog2(STROBE_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // f = {stop, parity, d7..d0}; odd parity over data plus parity bit, stop must be 1
  function automatic logic frame_ok(input logic [9:0] f);
    return (^f[8:0]) & f[9];
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [9:0]             shreg_q, shreg_d;
  logic [TO_W-1:0]        tmo_q, tmo_d;
  logic                   ext_q, ext_d;
  logic                   rel_q, rel_d;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic [4:0]             sc1_q, sc1_d;
  logic [4:0]             sc0_q, sc0_d;
  logic [ST_W-1:0]        strobe_cnt_q, strobe_cnt_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  logic       clk_s, data_s, fe_s;
  logic       push_s, pop_s, full_s, wr_ok_s;
  logic [9:0] push_entry_s;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fe_s   = clk_prev_q & ~clk_s;

  // Next-state logic for synchroniser, frame FSM, FIFO and display outputs
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d   = clk_s;
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    tmo_d        = tmo_q;
    ext_d        = ext_q;
    rel_d        = rel_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    sc1_d        = sc1_q;
    sc0_d        = sc0_q;
    strobe_cnt_d = strobe_cnt_q;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;
    push_s       = 1'b0;
    push_entry_s = 10'd0;

    case (state_q)
      S_IDLE: begin
        tmo_d = {TO_W{1'b0}};
        if (fe_s && !data_s) begin
          state_d  = S_SHIFT;
          bitcnt_d = 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (fe_s) begin
          shreg_d  = {data_s, shreg_q[9:1]};
          tmo_d    = {TO_W{1'b0}};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd10) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_SHIFT;
          end
        end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          tmo_d       = {TO_W{1'b0}};
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!frame_ok(shreg_q)) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          rel_d       = 1'b0;
        end else if (shreg_q[7:0] == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shreg_q[7:0] == 8'hF0) begin
          rel_d = 1'b1;
        end else begin
          push_s       = 1'b1;
          push_entry_s = {ext_q, rel_q, shreg_q[7:0]};
          ext_d        = 1'b0;
          rel_d        = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept
    pop_s   = (count_q != {(PTR_W+1){1'b0}}) && evt_ready;
    full_s  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    wr_ok_s = push_s && (!full_s || pop_s);

    if (push_s && !wr_ok_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = 1'b0;
    end

    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = push_entry_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_ok_s && !pop_s) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!wr_ok_s && pop_s) begin
      count_d = count_q - (PTR_W+1)'(1);
    end else begin
      count_d = count_q;
    end

    if (wr_ok_s && push_entry_s[8]) begin
      sc1_d        = {1'b0, push_entry_s[7:4]};
      sc0_d        = {1'b0, push_entry_s[3:0]};
      strobe_cnt_d = ST_W'(STROBE_CYCLES);
    end else if (strobe_cnt_q != {ST_W{1'b0}}) begin
      strobe_cnt_d = strobe_cnt_q - ST_W'(1);
    end else begin
      strobe_cnt_d = strobe_cnt_q;
    end
  end

  // State registers; pins synchronise to idle-high so reset never fakes a falling edge
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= {SYNC_STAGES{1'b1}};
      data_sync_q  <= {SYNC_STAGES{1'b1}};
      clk_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      bitcnt_q     <= 4'd0;
      shreg_q      <= 10'd0;
      tmo_q        <= {TO_W{1'b0}};
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {(PTR_W+1){1'b0}};
      sc1_q        <= 5'h1F;
      sc0_q        <= 5'h1F;
      strobe_cnt_q <= {ST_W{1'b0}};
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sc1_q        <= sc1_d;
      sc0_q        <= sc0_d;
      strobe_cnt_q <= strobe_cnt_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evt_valid    = (count_q != {(PTR_W+1){1'b0}});
  assign evt_code     = mem_q[rd_ptr_q][7:0];
  assign evt_release  = mem_q[rd_ptr_q][8];
  assign evt_extended = mem_q[rd_ptr_q][9];
  assign scancode1    = sc1_q;
  assign scancode0    = sc0_q;
  assign strobe_out   = (strobe_cnt_q != {ST_W{1'b0}});
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus queues expected events, a monitor
// pops and compares them whenever the DUT hands an event to the consumer.
module tb_ps2_scancode_rx;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_release;
  logic       evt_extended;
  logic [4:0] scancode1;
  logic [4:0] scancode0;
  logic       strobe_out;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  int strobe_len = 0;
  int strobe_runs = 0;
  logic [9:0] exp_q [$];
  logic [9:0] exp_e;

  ps2_scancode_rx #(
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(50), .FIFO_DEPTH(4), .STROBE_CYCLES(100)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_release(evt_release), .evt_extended(evt_extended),
    .scancode1(scancode1), .scancode0(scancode0), .strobe_out(strobe_out),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
    end
  endtask

  // Monitor: pulse counting, strobe length and event scoreboard, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
      if (strobe_out) begin
        strobe_len++;
      end else if (strobe_len != 0) begin
        check("strobe_len", strobe_len, 100);
        strobe_runs++;
        strobe_len = 0;
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: got 'h%0h, expected none",
                   {evt_extended, evt_release, evt_code});
        end else begin
          exp_e = exp_q.pop_front();
          check("evt", int'({evt_extended, evt_release, evt_code}), int'(exp_e));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(8);
    ps2_clk = 1'b0;
    cyc(8);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    cyc(20);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      cyc(1);
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int e0, o0, r0;
    logic [7:0] codes [6];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b1;
    cyc(5);
    check("rst_valid", evt_valid, 0);
    check("rst_sc1", scancode1, 5'h1F);
    check("rst_sc0", scancode0, 5'h1F);
    check("rst_strobe", strobe_out, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    cyc(5);

    // make, break of 1C
    r0 = strobe_runs;
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b01, 8'h1C});
    send_frame(8'h1C, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    cyc(150);
    drain("t1_drain");
    check("t1_sc1", scancode1, 5'h01);
    check("t1_sc0", scancode0, 5'h0C);
    check("t1_strobe_runs", strobe_runs - r0, 1);

    // extended break 75
    r0 = strobe_runs;
    exp_q.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
    cyc(150);
    drain("t2_drain");
    check("t2_sc1", scancode1, 5'h07);
    check("t2_sc0", scancode0, 5'h05);
    check("t2_strobe_runs", strobe_runs - r0, 1);

    // parity error then good frame
    e0 = err_seen;
    send_frame(8'h1C, 1'b1);
    check("t3_err", err_seen - e0, 1);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0);
    drain("t3_drain");
    check("t3_err_after", err_seen - e0, 1);

    // clock stalls after 5 bits
    e0 = err_seen;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(30);
    check("t4_err_early", err_seen - e0, 0);
    cyc(50);
    check("t4_err", err_seen - e0, 1);
    check("t4_valid", evt_valid, 0);
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0);
    drain("t4_drain");

    // overflow with consumer stalled
    evt_ready = 1'b0;
    o0 = ovf_seen;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, codes[i]});
    for (int i = 0; i < 6; i++) send_frame(codes[i], 1'b0);
    check("t5_ovf", ovf_seen - o0, 2);
    check("t5_valid", evt_valid, 1);
    check("t5_head", evt_code, 8'h15);
    evt_ready = 1'b1;
    drain("t5_drain");
    cyc(5);
    check("t5_empty", evt_valid, 0);

    // reset during bit 6 of C0; remaining bits are all ones
    e0 = err_seen;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(100);
    check("t6_err", err_seen - e0, 0);
    check("t6_valid", evt_valid, 0);
    check("t6_sc1", scancode1, 5'h1F);
    check("t6_sc0", scancode0, 5'h1F);
    check("t6_strobe", strobe_out, 0);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0);
    drain("t6_drain");
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Parametrised PS/2 keyboard receiver, fully synchronous to `sys_clk`. Samples the raw PS/2 clock and data pins, assembles and checks 11-bit frames, and decodes the `E0` (extended) and `F0` (break) prefixes into key events. Events are queued in a FIFO with a valid/ready interface for the downstream consumer. Keeps the two-digit release-code display outputs and the retriggerable activity strobe used by the display logic.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on `ps2_clk` and `ps2_data`; minimum 2.
- `TIMEOUT_CYCLES`, 100000: maximum `sys_clk` cycles allowed between falling edges inside a frame.
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2, minimum 2.
- `STROBE_CYCLES`, 10000000: strobe duration in cycles (100 ms at 100 MHz).

Ports:
- `sys_clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous to `sys_clk`.
- `ps2_data`, in, 1: raw PS/2 data, asynchronous to `sys_clk`.
- `evt_valid`, out, 1: FIFO non-empty.
- `evt_ready`, in, 1: consumer accepts the head entry.
- `evt_code`, out, 8: head scancode.
- `evt_release`, out, 1: head entry is a break code (preceded by `F0`).
- `evt_extended`, out, 1: head entry was preceded by `E0`.
- `scancode1`, out, 5: `{0, code[7:4]}` of the last accepted release event.
- `scancode0`, out, 5: `{0, code[3:0]}` of the last accepted release event.
- `strobe_out`, out, 1: high for `STROBE_CYCLES` cycles after each accepted release event.
- `frame_err`, out, 1: one-cycle pulse on a parity, stop-bit or timeout error.
- `overflow`, out, 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Both pins pass through `SYNC_STAGES` flops. A falling edge `fe` is detected when the previous synchronised clock is 1 and the current one is 0. Data is sampled on the synchronised value in the `fe` cycle.
- Frame format, LSB first: start bit 0, data bits d0–d7, odd parity bit, stop bit 1.
- FSM states:
  - **IDLE**: an `fe` with data 0 moves to SHIFT with `bitcnt=1`. An `fe` with data 1 is ignored.
  - **SHIFT**: each `fe` shifts in one bit and increments `bitcnt`. The `fe` that captures the stop bit (`bitcnt=10`) moves to CHECK.
  - **CHECK**: lasts exactly one cycle, then returns to IDLE.
- Timeout: a counter clears on every `fe` and increments in SHIFT otherwise. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, the partial frame is discarded, and `frame_err` pulses.
- CHECK is valid when the XOR of d0–d7 and the parity bit equals 1 and the stop bit equals 1.
  - Invalid frame: `frame_err` pulses, and the `ext` and `rel` flags clear.
- Valid byte handling:
  - `E0`: sets `ext`.
  - `F0`: sets `rel`.
  - Any other byte: pushes `{ext, rel, byte}` and clears both flags.
- Push while full: the entry is dropped, `overflow` pulses, and the flags still clear. A push and a pop in the same cycle while full both succeed.
- FIFO is first-word-fall-through. A pop occurs when `evt_valid && evt_ready`.
- A successfully pushed entry with `rel=1` also:
  - updates `scancode1` and `scancode0`;
  - loads the strobe counter with `STROBE_CYCLES`.
- `strobe_out` is 1 while the strobe counter is nonzero. A retrigger reloads the counter.
- Reset values:
  - FSM IDLE, flags 0, FIFO empty;
  - `evt_valid`=0;
  - `scancode1`=`scancode0`=5'h1F;
  - `strobe_out`=0, `frame_err`=0, `overflow`=0;
  - counters 0.
- Reset in the middle of a frame discards it. Reception restarts only on a new start bit.

## Timing
- Pin-to-detect latency: `SYNC_STAGES`+1 cycles.
- Stop-bit `fe` in cycle E: CHECK in cycle E+1, FIFO write at the end of E+1.
- `evt_valid` rises at E+2 if the FIFO was empty.
- `scancode*` update and `strobe_out` rise at E+2.
- `strobe_out` stays high for exactly `STROBE_CYCLES` cycles.
- `frame_err` and `overflow` are asserted in cycle E+2 for one cycle.
- FIFO data is stable while `evt_valid && !evt_ready`.
- Minimum PS/2 clock half-period supported: `SYNC_STAGES`+2 `sys_clk` cycles.

## Test plan
- Frames `1C`, `F0`, `1C` with `evt_ready`=1 → two events: `{0,0,1C}` then `{0,1,1C}`; `scancode1`=5'h01, `scancode0`=5'h0C; `strobe_out` high for `STROBE_CYCLES`=100 in the test config.
- Frames `E0`, `F0`, `75` → one event `{ext=1, rel=1, 75}`.
- Frame `1C` with parity flipped → `frame_err` pulse, no event; a following good `1C` is received normally.
- Clock stops after 5 bits for `TIMEOUT_CYCLES`=50 → `frame_err` at cycle 50, FSM IDLE, then a clean frame is accepted.
- `FIFO_DEPTH`=4, `evt_ready`=0, six make codes → four entries kept in order, `overflow` pulses twice; entries drain in order once `evt_ready`=1.
- `reset` asserted during bit 6, then the frame's remaining bits arrive → no event, no `frame_err`; all outputs hold their reset values until the next frame.
